// File: rtl/core_pkg.sv
// Shared core definitions: opcode map, M-extension func7, forwarding encodings,
// MD sequencer states and the hazard tracker entry layout.
package core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } trk_entry_t;

  // A source only matches a live, non-x0 destination it actually reads.
  function automatic logic src_match(trk_entry_t e, logic [4:0] src, logic used);
    return used && e.v && (src != 5'd0) && (e.rd == src);
  endfunction

  function automatic logic [1:0] fwd_sel(trk_entry_t ex_e, trk_entry_t mem_e, trk_entry_t wb_e,
                                         logic [4:0] src, logic used);
    logic [1:0] sel;
    if (src_match(ex_e, src, used) && !ex_e.ld) begin
      sel = FWD_EX;
    end else if (src_match(mem_e, src, used)) begin
      sel = FWD_MEM;
    end else if (src_match(wb_e, src, used)) begin
      sel = FWD_RF;   // register file writes through in WB
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage request and hazard-control response bundle between the core and hazard_ctrl.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [6:0] id_func7;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       br_taken;
  logic       stall;
  logic       bubble_ex;
  logic       hold_ex;
  logic       flush;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       md_busy;

  modport master (
    output id_valid, id_opcode, id_func7, id_rs1, id_rs2, id_rd, br_taken,
    input  stall, bubble_ex, hold_ex, flush, fwd_a, fwd_b, md_busy
  );

  modport slave (
    input  id_valid, id_opcode, id_func7, id_rs1, id_rs2, id_rd, br_taken,
    output stall, bubble_ex, hold_ex, flush, fwd_a, fwd_b, md_busy
  );
endinterface

// File: rtl/hazard_src_decode.sv
// Classifies the ID instruction: which sources it reads, whether it writes rd,
// and whether it is a load or a multi-cycle MUL/DIV.
module hazard_src_decode
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [6:0] func7,
  input  logic [4:0] rd,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load,
  output logic       is_md
);

  logic writes_raw_s;

  // Operand usage and destination class per opcode
  always_comb begin
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    writes_raw_s = 1'b1;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
      end
      OP_STORE, OP_BRANCH: begin
        uses_rs1     = 1'b1;
        uses_rs2     = 1'b1;
        writes_raw_s = 1'b0;
      end
      default: begin
        uses_rs1 = 1'b0;
      end
    endcase
  end

  assign writes_rd = writes_raw_s && (rd != 5'd0);
  assign is_load   = (opcode == OP_LOAD);
  assign is_md     = (opcode == OP_R) && (func7 == FUNC7_MULDIV);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations, raises load-use
// stalls, registered forwarding selects, branch flushes and MUL/DIV EX holds.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MD_LAT = 8
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hif
);

  localparam logic [3:0] CNT_INIT = (MD_LAT > 1) ? 4'(MD_LAT - 2) : 4'd0;
  localparam logic       MD_HOLDS = (MD_LAT > 1) ? 1'b1 : 1'b0;

  logic       uses_rs1_s, uses_rs2_s, writes_rd_s, is_load_s, is_md_s;
  logic       use1_s, use2_s, load_use_s;
  logic       flush_s, stall_s, bubble_s, hold_s, issue_s, md_enter_s;
  trk_entry_t ex_r, mem_r, wb_r, id_entry_s;
  logic [1:0] fwd_a_r, fwd_b_r;
  logic [1:0] fwd_a_nxt_s, fwd_b_nxt_s;
  md_state_e  state_r, state_nxt_s;
  logic [3:0] cnt_r, cnt_nxt_s;
  logic       md_busy_r;

  hazard_src_decode u_dec (
    .opcode    (hif.id_opcode),
    .func7     (hif.id_func7),
    .rd        (hif.id_rd),
    .uses_rs1  (uses_rs1_s),
    .uses_rs2  (uses_rs2_s),
    .writes_rd (writes_rd_s),
    .is_load   (is_load_s),
    .is_md     (is_md_s)
  );

  assign use1_s     = hif.id_valid && uses_rs1_s;
  assign use2_s     = hif.id_valid && uses_rs2_s;
  assign load_use_s = ex_r.ld && (src_match(ex_r, hif.id_rs1, use1_s) ||
                                  src_match(ex_r, hif.id_rs2, use2_s));

  // A redirect during an MD hold cannot be legal, so it is dropped there.
  assign flush_s    = rst && hif.br_taken && !md_busy_r;
  assign stall_s    = rst && !flush_s && (load_use_s || md_busy_r);
  assign bubble_s   = rst && !flush_s && !md_busy_r && load_use_s;
  assign hold_s     = rst && md_busy_r;
  assign issue_s    = hif.id_valid && !stall_s && !flush_s;
  assign md_enter_s = issue_s && is_md_s && !hold_s && MD_HOLDS;

  assign id_entry_s.v  = issue_s && writes_rd_s;
  assign id_entry_s.rd = hif.id_rd;
  assign id_entry_s.ld = is_load_s;

  assign fwd_a_nxt_s = issue_s ? fwd_sel(ex_r, mem_r, wb_r, hif.id_rs1, use1_s) : FWD_RF;
  assign fwd_b_nxt_s = issue_s ? fwd_sel(ex_r, mem_r, wb_r, hif.id_rs2, use2_s) : FWD_RF;

  // Destination tracker and forwarding selects, advancing in step with ID/EX
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_r    <= '0;
      mem_r   <= '0;
      wb_r    <= '0;
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (!hold_s) begin
      ex_r    <= id_entry_s;
      mem_r   <= ex_r;
      wb_r    <= mem_r;
      fwd_a_r <= fwd_a_nxt_s;
      fwd_b_r <= fwd_b_nxt_s;
    end else begin
      mem_r   <= '0;
      wb_r    <= mem_r;
    end
  end

  // MD sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      md_busy_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      md_busy_r <= (state_nxt_s == MD_BUSY);
    end
  end

  // MD sequencer next state: busy for MD_LAT-1 cycles after the op enters EX
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (md_enter_s) begin
          state_nxt_s = MD_BUSY;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  assign hif.stall     = stall_s;
  assign hif.bubble_ex = bubble_s;
  assign hif.hold_ex   = hold_s;
  assign hif.flush     = flush_s;
  assign hif.fwd_a     = fwd_a_r;
  assign hif.fwd_b     = fwd_b_r;
  assign hif.md_busy   = md_busy_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_LAT=4: forwarding, load-use, x0,
// MUL hold, flush priority and reset in the middle of an MD hold.
module tb_hazard_ctrl;
  import core_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_id(input logic v, input logic [6:0] op, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    hif.id_valid  = v;
    hif.id_opcode = op;
    hif.id_func7  = f7;
    hif.id_rs1    = rs1;
    hif.id_rs2    = rs2;
    hif.id_rd     = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2;
    hif.br_taken = 1'b1;
    set_id(1'b1, OP_LOAD, 7'd0, 5'd1, 5'd0, 5'd5);
    #1;
    checks++; if (hif.flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", hif.flush); end
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", hif.stall); end
    checks++; if (hif.hold_ex !== 1'b0) begin errors++; $display("FAIL reset_hold got %0b want 0", hif.hold_ex); end
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL reset_md_busy got %0b want 0", hif.md_busy); end
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd got %0d/%0d want 0/0", hif.fwd_a, hif.fwd_b); end
    hif.br_taken = 1'b0;
    set_id(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fwd_ex();
    set_id(1'b1, OP_R, 7'd0, 5'd1, 5'd2, 5'd5);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall0 got %0b want 0", hif.stall); end
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd5, 5'd3, 5'd6);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall1 got %0b want 0", hif.stall); end
    tick();
    checks++; if (hif.fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_ex_a got %0d want 1", hif.fwd_a); end
    checks++; if (hif.fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_ex_b got %0d want 0", hif.fwd_b); end
    drain();
  endtask

  task automatic test_fwd_mem();
    set_id(1'b1, OP_R, 7'd0, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd3, 5'd4, 5'd6);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd5, 5'd5, 5'd7);
    tick();
    checks++; if (hif.fwd_a !== 2'd2 || hif.fwd_b !== 2'd2) begin errors++; $display("FAIL fwd_mem got %0d/%0d want 2/2", hif.fwd_a, hif.fwd_b); end
    drain();
    set_id(1'b1, OP_R, 7'd0, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd5, 5'd1, 5'd5);
    tick();
    checks++; if (hif.fwd_a !== 2'd1 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_chain got %0d/%0d want 1/0", hif.fwd_a, hif.fwd_b); end
    set_id(1'b1, OP_R, 7'd0, 5'd5, 5'd5, 5'd8);
    tick();
    checks++; if (hif.fwd_a !== 2'd1 || hif.fwd_b !== 2'd1) begin errors++; $display("FAIL fwd_prio got %0d/%0d want 1/1", hif.fwd_a, hif.fwd_b); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, OP_LOAD, 7'd0, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd0, 5'd5, 5'd7);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", hif.stall); end
    checks++; if (hif.bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_bubble got %0b want 1", hif.bubble_ex); end
    tick();
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd got %0d/%0d want 0/0", hif.fwd_a, hif.fwd_b); end
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0 || hif.bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_release got %0b/%0b want 0/0", hif.stall, hif.bubble_ex); end
    tick();
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd got %0d/%0d want 0/2", hif.fwd_a, hif.fwd_b); end
    drain();
  endtask

  task automatic test_x0();
    set_id(1'b1, OP_IMM, 7'd0, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd0, 5'd0, 5'd8);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %0b want 0", hif.stall); end
    tick();
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL x0_fwd got %0d/%0d want 0/0", hif.fwd_a, hif.fwd_b); end
    set_id(1'b1, OP_LOAD, 7'd0, 5'd1, 5'd0, 5'd0);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd0, 5'd0, 5'd8);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL x0_load_stall got %0b want 0", hif.stall); end
    drain();
  endtask

  task automatic test_md();
    set_id(1'b1, OP_R, FUNC7_MULDIV, 5'd1, 5'd2, 5'd9);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL md_pre_stall got %0b want 0", hif.stall); end
    tick();
    checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL md_enter got %0b want 1", hif.md_busy); end
    set_id(1'b1, OP_R, 7'd0, 5'd9, 5'd9, 5'd10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (hif.hold_ex !== 1'b1 || hif.stall !== 1'b1 || hif.md_busy !== 1'b1)
        begin errors++; $display("FAIL md_hold_c%0d got h%0b s%0b b%0b want 1/1/1", i, hif.hold_ex, hif.stall, hif.md_busy); end
      checks++; if (hif.bubble_ex !== 1'b0) begin errors++; $display("FAIL md_bubble_c%0d got %0b want 0", i, hif.bubble_ex); end
      tick();
    end
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL md_exit got %0b want 0", hif.md_busy); end
    @(negedge clk);
    checks++; if (hif.hold_ex !== 1'b0 || hif.stall !== 1'b0) begin errors++; $display("FAIL md_release got %0b/%0b want 0/0", hif.hold_ex, hif.stall); end
    tick();
    checks++; if (hif.fwd_a !== 2'd1 || hif.fwd_b !== 2'd1) begin errors++; $display("FAIL md_fwd got %0d/%0d want 1/1", hif.fwd_a, hif.fwd_b); end
    drain();
  endtask

  task automatic test_flush();
    set_id(1'b1, OP_LOAD, 7'd0, 5'd1, 5'd0, 5'd5);
    tick();
    set_id(1'b1, OP_R, 7'd0, 5'd0, 5'd5, 5'd7);
    hif.br_taken = 1'b1;
    @(negedge clk);
    checks++; if (hif.flush !== 1'b1) begin errors++; $display("FAIL fl_flush got %0b want 1", hif.flush); end
    checks++; if (hif.stall !== 1'b0 || hif.bubble_ex !== 1'b0) begin errors++; $display("FAIL fl_stall got %0b/%0b want 0/0", hif.stall, hif.bubble_ex); end
    tick();
    hif.br_taken = 1'b0;
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL fl_fwd got %0d/%0d want 0/0", hif.fwd_a, hif.fwd_b); end
    set_id(1'b1, OP_R, 7'd0, 5'd7, 5'd7, 5'd12);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL fl_next_stall got %0b want 0", hif.stall); end
    tick();
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL fl_ex_invalid got %0d/%0d want 0/0", hif.fwd_a, hif.fwd_b); end
    drain();
  endtask

  task automatic test_rst_mid_md();
    set_id(1'b1, OP_R, FUNC7_MULDIV, 5'd1, 5'd2, 5'd9);
    tick();
    set_id(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL rmd_busy got %0b want 1", hif.md_busy); end
    rst = 1'b0;
    #1;
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rmd_md_busy got %0b want 0", hif.md_busy); end
    checks++; if (hif.stall !== 1'b0 || hif.hold_ex !== 1'b0) begin errors++; $display("FAIL rmd_outs got %0b/%0b want 0/0", hif.stall, hif.hold_ex); end
    tick();
    rst = 1'b1;
    set_id(1'b1, OP_R, 7'd0, 5'd9, 5'd9, 5'd13);
    @(negedge clk);
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rmd_issue_stall got %0b want 0", hif.stall); end
    tick();
    checks++; if (hif.fwd_a !== 2'd0 || hif.fwd_b !== 2'd0) begin errors++; $display("FAIL rmd_fwd got %0d/%0d want 0/0", hif.fwd_a, hif.fwd_b); end
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rmd_after got %0b want 0", hif.md_busy); end
    drain();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    hif.br_taken = 1'b0;
    set_id(1'b0, 7'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_x0();
    test_md();
    test_flush();
    test_rst_mid_md();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
